// File: rtl/exe_stage.sv
// exe_stage: RISC-V execute stage with ALU, branch resolve and EXE/MEM register.
// Define MUL_EN to build the iterative MUL/MULH/MULHU unit and its BUSY state.
module exe_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            registerWriteEnable_i,
  input  logic            dataWriteEnable_i,
  input  logic            regSelect_i,
  input  logic [2:0]      branchCtr_i,
  input  logic [3:0]      aluCtr_i,
  input  logic [XLEN-1:0] dataA_i,
  input  logic [XLEN-1:0] dataB_i,
  input  logic [REGW-1:0] regDst_i,
  input  logic [XLEN-1:0] offset_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] storeData_o,
  output logic            registerWriteEnable_o,
  output logic            dataWriteEnable_o,
  output logic            regSelect_o,
  output logic [REGW-1:0] regDst_o,
  output logic            branchTaken_o,
  output logic [XLEN-1:0] branchTarget_o,
  output logic            stall_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] aluRes;
  logic            taken;
  logic            mulDone;
  logic            mulHold;
  logic [XLEN-1:0] mulRes;
  logic [XLEN-1:0] holdStore;
  logic            holdRwe;
  logic            holdDwe;
  logic            holdSel;
  logic [REGW-1:0] holdDst;

  assign shamt = dataB_i[SHW-1:0];

  // Single-cycle ALU; unused and reserved codes yield zero
  always_comb begin
    aluRes = '0;
    case (aluCtr_i)
      4'd0:    aluRes = dataA_i + dataB_i;
      4'd1:    aluRes = dataA_i - dataB_i;
      4'd2:    aluRes = dataA_i & dataB_i;
      4'd3:    aluRes = dataA_i | dataB_i;
      4'd4:    aluRes = dataA_i ^ dataB_i;
      4'd5:    aluRes = dataA_i << shamt;
      4'd6:    aluRes = dataA_i >> shamt;
      4'd7:    aluRes = $signed(dataA_i) >>> shamt;
      4'd8:    aluRes = {{(XLEN-1){1'b0}},
                         $signed(dataA_i) < $signed(dataB_i)};
      4'd9:    aluRes = {{(XLEN-1){1'b0}}, dataA_i < dataB_i};
      4'd10:   aluRes = dataB_i;
      default: aluRes = '0;
    endcase
  end

  // Branch condition; JAL always redirects
  always_comb begin
    taken = 1'b0;
    case (branchCtr_i)
      3'd1:    taken = dataA_i == dataB_i;
      3'd2:    taken = dataA_i != dataB_i;
      3'd3:    taken = $signed(dataA_i) < $signed(dataB_i);
      3'd4:    taken = $signed(dataA_i) >= $signed(dataB_i);
      3'd5:    taken = dataA_i < dataB_i;
      3'd6:    taken = dataA_i >= dataB_i;
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

`ifdef MUL_EN
  localparam int CW = $clog2(XLEN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            stateQ;
  state_t            stateD;
  logic              isMul;
  logic              isMulh;
  logic              issue;
  logic [CW-1:0]     cntQ;
  logic [2*XLEN-1:0] accQ;
  logic [2*XLEN-1:0] addend;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   magAQ;
  logic [XLEN-1:0]   magBQ;
  logic              negQ;
  logic              hiQ;

  assign isMul = valid_i && (aluCtr_i == 4'd11 ||
                             aluCtr_i == 4'd12 ||
                             aluCtr_i == 4'd13);
  assign isMulh = aluCtr_i == 4'd12;

  assign addend = magBQ[cntQ]
                ? ({{XLEN{1'b0}}, magAQ} << cntQ) : '0;
  assign accNext = accQ + addend;
  assign prod = negQ ? -accNext : accNext;
  assign mulRes = hiQ ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // Next state, stall request and issue/complete strobes
  always_comb begin
    stateD  = stateQ;
    stall_o = 1'b0;
    issue   = 1'b0;
    mulDone = 1'b0;
    mulHold = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (isMul) begin
          stateD  = BUSY;
          stall_o = 1'b1;
          issue   = 1'b1;
          mulHold = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cntQ == CW'(XLEN-1)) begin
          stateD  = IDLE;
          mulDone = 1'b1;
        end else begin
          mulHold = 1'b1;
        end
      end
    endcase
    if (rst) stall_o = 1'b0;
  end

  // Capture magnitudes and control on issue, then one shift-add per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntQ      <= '0;
      accQ      <= '0;
      magAQ     <= '0;
      magBQ     <= '0;
      negQ      <= 1'b0;
      hiQ       <= 1'b0;
      holdStore <= '0;
      holdRwe   <= 1'b0;
      holdDwe   <= 1'b0;
      holdSel   <= 1'b0;
      holdDst   <= '0;
    end else if (issue) begin
      cntQ      <= '0;
      accQ      <= '0;
      magAQ     <= (isMulh && dataA_i[XLEN-1]) ? -dataA_i : dataA_i;
      magBQ     <= (isMulh && dataB_i[XLEN-1]) ? -dataB_i : dataB_i;
      negQ      <= isMulh && (dataA_i[XLEN-1] ^ dataB_i[XLEN-1]);
      hiQ       <= aluCtr_i != 4'd11;
      holdStore <= dataB_i;
      holdRwe   <= registerWriteEnable_i;
      holdDwe   <= dataWriteEnable_i;
      holdSel   <= regSelect_i;
      holdDst   <= regDst_i;
    end else if (stateQ == BUSY) begin
      accQ <= accNext;
      cntQ <= cntQ + 1'b1;
    end
  end
`else
  assign stall_o   = 1'b0;
  assign mulDone   = 1'b0;
  assign mulHold   = 1'b0;
  assign mulRes    = '0;
  assign holdStore = '0;
  assign holdRwe   = 1'b0;
  assign holdDwe   = 1'b0;
  assign holdSel   = 1'b0;
  assign holdDst   = '0;
`endif

  // EXE/MEM register: product on completion, bubble while busy or idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o               <= 1'b0;
      result_o              <= '0;
      storeData_o           <= '0;
      registerWriteEnable_o <= 1'b0;
      dataWriteEnable_o     <= 1'b0;
      regSelect_o           <= 1'b0;
      regDst_o              <= '0;
      branchTaken_o         <= 1'b0;
      branchTarget_o        <= '0;
    end else if (mulDone) begin
      valid_o               <= 1'b1;
      result_o              <= mulRes;
      storeData_o           <= holdStore;
      registerWriteEnable_o <= holdRwe;
      dataWriteEnable_o     <= holdDwe;
      regSelect_o           <= holdSel;
      regDst_o              <= holdDst;
      branchTaken_o         <= 1'b0;
    end else if (mulHold || !valid_i) begin
      valid_o               <= 1'b0;
      registerWriteEnable_o <= 1'b0;
      dataWriteEnable_o     <= 1'b0;
      branchTaken_o         <= 1'b0;
    end else begin
      valid_o               <= 1'b1;
      result_o              <= aluRes;
      storeData_o           <= dataB_i;
      registerWriteEnable_o <= registerWriteEnable_i;
      dataWriteEnable_o     <= dataWriteEnable_i;
      regSelect_o           <= regSelect_i;
      regDst_o              <= regDst_i;
      branchTaken_o         <= taken;
      branchTarget_o        <= pc_i + offset_i;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage.
// Multiply cases follow MUL_EN the same way the design does.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        rwe_i;
  logic        dwe_i;
  logic        sel_i;
  logic [2:0]  br_i;
  logic [3:0]  alu_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  dst_i;
  logic [31:0] off_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic [31:0] store_o;
  logic        rwe_o;
  logic        dwe_o;
  logic        sel_o;
  logic [4:0]  dst_o;
  logic        taken_o;
  logic [31:0] target_o;
  logic        stall_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_i               (valid_i),
    .pc_i                  (pc_i),
    .registerWriteEnable_i (rwe_i),
    .dataWriteEnable_i     (dwe_i),
    .regSelect_i           (sel_i),
    .branchCtr_i           (br_i),
    .aluCtr_i              (alu_i),
    .dataA_i               (a_i),
    .dataB_i               (b_i),
    .regDst_i              (dst_i),
    .offset_i              (off_i),
    .valid_o               (valid_o),
    .result_o              (result_o),
    .storeData_o           (store_o),
    .registerWriteEnable_o (rwe_o),
    .dataWriteEnable_o     (dwe_o),
    .regSelect_o           (sel_o),
    .regDst_o              (dst_o),
    .branchTaken_o         (taken_o),
    .branchTarget_o        (target_o),
    .stall_o               (stall_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] alu,
                       input logic [2:0] br, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] off, input logic [4:0] dst,
                       input logic rwe, input logic dwe, input logic sel);
    valid_i = v;
    alu_i   = alu;
    br_i    = br;
    a_i     = a;
    b_i     = b;
    pc_i    = pc;
    off_i   = off;
    dst_i   = dst;
    rwe_i   = rwe;
    dwe_i   = dwe;
    sel_i   = sel;
  endtask

`ifdef MUL_EN
  task automatic run_mul(input string tag, input logic [3:0] alu,
                         input logic [2:0] br, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int bad;
    bad = 0;
    drive(1, alu, br, a, b, 32'h40, 32'h4, 5'd9, 1, 0, 1);
    #1;
    check({tag, "_stall_issue"}, stall_o, 1);
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (stall_o !== 1'b1 || valid_o !== 1'b0) bad++;
    end
    check({tag, "_busy_cycles_bad"}, bad, 0);
    tick;
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_dst"}, dst_o, 9);
    check({tag, "_rwe"}, rwe_o, 1);
    check({tag, "_taken"}, taken_o, 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_target", target_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_ctrl", {rwe_o, dwe_o, sel_o, taken_o, dst_o}, 0);
    tick;
    tick;
    rst = 1'b0;

    drive(1, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd3, 1, 0, 0);
    #1;
    check("add_stall", stall_o, 0);
    tick;
    check("add_result", result_o, 32'h0);
    check("add_valid", valid_o, 1);
    check("add_dst", dst_o, 3);
    check("add_rwe", rwe_o, 1);

    drive(1, 7, 0, 32'h80000000, 32'h4, 0, 0, 5'd4, 1, 0, 0);
    tick;
    check("sra", result_o, 32'hF8000000);

    drive(1, 8, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd5, 1, 0, 0);
    tick;
    check("slt", result_o, 32'h1);

    drive(1, 9, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd5, 1, 0, 0);
    tick;
    check("sltu", result_o, 32'h0);

    drive(1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0, 0, 1, 1);
    tick;
    check("st_addr", result_o, 32'hDEADBEFF);
    check("st_data", store_o, 32'hDEADBEEF);
    check("st_ctrl", {rwe_o, dwe_o, sel_o}, 3'b011);

    drive(1, 0, 3, 32'hFFFFFFFE, 32'h3, 32'h100, 32'hFFFFFFF0,
          5'd0, 0, 0, 0);
    tick;
    check("blt_taken", taken_o, 1);
    check("blt_target", target_o, 32'hF0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    check("flush_taken", taken_o, 0);
    check("flush_valid", valid_o, 0);
    check("flush_target_hold", target_o, 32'hF0);

    drive(1, 0, 3, 32'h3, 32'h3, 32'h100, 32'hFFFFFFF0,
          5'd0, 0, 0, 0);
    tick;
    check("blt_not_taken", taken_o, 0);
    check("blt_nt_valid", valid_o, 1);

    drive(1, 10, 7, 32'h0, 32'h55, 32'h200, 32'h8, 5'd1, 1, 0, 0);
    tick;
    check("jal_taken", taken_o, 1);
    check("jal_target", target_o, 32'h208);
    check("passb", result_o, 32'h55);

    drive(0, 0, 0, 32'h1, 32'h1, 0, 0, 5'd2, 1, 1, 0);
    tick;
    check("bub_valid", valid_o, 0);
    check("bub_we", {rwe_o, dwe_o}, 0);
    check("bub_taken", taken_o, 0);
    check("bub_result_hold", result_o, 32'h55);

    drive(1, 0, 0, 32'h1, 32'h2, 0, 0, 5'd7, 1, 0, 0);
    tick;
    check("pre_rst_result", result_o, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_result", result_o, 0);
    check("arst_dst", dst_o, 0);
    check("arst_stall", stall_o, 0);
    #1;
    valid_i = 1'b0;
    rst = 1'b0;
    tick;
    check("post_rst_valid", valid_o, 0);

    drive(1, 1, 0, 32'h5, 32'h7, 0, 0, 5'd8, 1, 0, 0);
    tick;
    check("sub_result", result_o, 32'hFFFFFFFE);
    check("sub_dst", dst_o, 8);

`ifdef MUL_EN
    run_mul("mul", 11, 0, 32'd7, 32'd6, 32'd42);
    drive(1, 0, 0, 32'h5, 32'h6, 0, 0, 5'd10, 1, 0, 0);
    #1;
    check("b2b_stall", stall_o, 0);
    tick;
    check("b2b_add", result_o, 32'd11);
    check("b2b_valid", valid_o, 1);
    check("b2b_dst", dst_o, 10);
    run_mul("mulh_neg", 12, 0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF);
    run_mul("mulhu", 13, 7, 32'hFFFFFFFF, 32'h2, 32'h1);
    run_mul("mul_m1", 11, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    run_mul("mulh_m1", 12, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    run_mul("mulh_min", 12, 0, 32'h80000000, 32'h2, 32'hFFFFFFFF);

    drive(1, 11, 0, 32'd7, 32'd6, 0, 0, 5'd9, 1, 0, 0);
    for (int k = 0; k < 10; k++) tick;
    #2;
    rst = 1'b1;
    #1;
    check("busy_rst_stall", stall_o, 0);
    check("busy_rst_valid", valid_o, 0);
    #1;
    valid_i = 1'b0;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (valid_o !== 1'b0) pulses++;
    end
    check("busy_rst_no_pulse", pulses, 0);
    drive(1, 0, 0, 32'h2, 32'h2, 0, 0, 5'd11, 1, 0, 0);
    #1;
    check("after_abort_stall", stall_o, 0);
    tick;
    check("after_abort_result", result_o, 32'd4);
    check("after_abort_valid", valid_o, 1);
`else
    drive(1, 11, 0, 32'd7, 32'd6, 0, 0, 5'd9, 1, 0, 0);
    #1;
    check("nomul_stall", stall_o, 0);
    tick;
    check("nomul_result", result_o, 32'd0);
    check("nomul_valid", valid_o, 1);
    check("nomul_dst", dst_o, 9);
    drive(1, 12, 0, 32'hFFFFFFFE, 32'h3, 0, 0, 5'd6, 1, 0, 0);
    tick;
    check("nomul_mulh", result_o, 32'd0);
    drive(1, 0, 0, 32'h2, 32'h2, 0, 0, 5'd11, 1, 0, 0);
    tick;
    check("nomul_next_add", result_o, 32'd4);
    check("nomul_next_valid", valid_o, 1);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    check("final_idle_valid", valid_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
